// File: rtl/position_overlay.sv
// Draws a square outline marker around the tracked centroid on the VGA pixel stream.
// A small IDLE/TRACK/COAST tracker holds the last good position for a bounded number of misses.
module position_overlay #(
   parameter int INPUT_WIDTH  = 11,
   parameter int COLOR_WIDTH  = 10,
   parameter int FRAME_X_MAX  = 640,
   parameter int FRAME_Y_MAX  = 480,
   parameter int BOX_HALF     = 8,
   parameter int COAST_FRAMES = 4,
   parameter logic [3*COLOR_WIDTH-1:0] TRACK_COLOR = 30'h3FF00000,
   parameter logic [3*COLOR_WIDTH-1:0] COAST_COLOR = 30'h1FF7FC00
) (
   input  logic                       clk,
   input  logic                       aresetn,
   input  logic                       enable,
   input  logic [INPUT_WIDTH-1:0]     vga_x,
   input  logic [INPUT_WIDTH-1:0]     vga_y,
   input  logic [3*COLOR_WIDTH-1:0]   pixel_in,
   input  logic [INPUT_WIDTH-1:0]     x_position,
   input  logic [INPUT_WIDTH-1:0]     y_position,
   input  logic                       xy_valid,
   output logic [3*COLOR_WIDTH-1:0]   pixel_out,
   output logic [1:0]                 track_state,
   output logic                       locked
);

   localparam int XW = INPUT_WIDTH + 1;
   localparam int MW = (COAST_FRAMES < 2) ? 1 : $clog2(COAST_FRAMES + 1);

   localparam logic [XW-1:0]        X_LIM   = XW'(FRAME_X_MAX);
   localparam logic [XW-1:0]        Y_LIM   = XW'(FRAME_Y_MAX);
   localparam logic signed [XW-1:0] BOX     = XW'(BOX_HALF);
   localparam logic [MW-1:0]        MISS_MAX = MW'(COAST_FRAMES);
   localparam logic [MW-1:0]        MISS_ONE = MW'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRACK = 2'd1,
      COAST = 2'd2
   } state_t;

   state_t                    state_q, state_d;
   logic [INPUT_WIDTH-1:0]    cx_q, cx_d;
   logic [INPUT_WIDTH-1:0]    cy_q, cy_d;
   logic [MW-1:0]             miss_cnt_q, miss_cnt_d;
   logic [3*COLOR_WIDTH-1:0]  pixel_out_q, pixel_out_d;

   logic                      result_good;
   logic signed [XW-1:0]      dx, dy, adx, ady;
   logic                      hit;

   // All-ones (no object) fails the range test naturally.
   assign result_good = ({1'b0, x_position} < X_LIM) && ({1'b0, y_position} < Y_LIM);

   always_comb begin
      state_d    = state_q;
      cx_d       = cx_q;
      cy_d       = cy_q;
      miss_cnt_d = miss_cnt_q;
      if (!enable) begin
         state_d    = IDLE;
         cx_d       = '0;
         cy_d       = '0;
         miss_cnt_d = '0;
      end else if (xy_valid) begin
         case (state_q)
            IDLE: begin
               if (result_good) begin
                  state_d = TRACK;
                  cx_d    = x_position;
                  cy_d    = y_position;
               end
            end
            TRACK: begin
               if (result_good) begin
                  cx_d = x_position;
                  cy_d = y_position;
               end else begin
                  state_d    = COAST;
                  miss_cnt_d = MISS_ONE;
               end
            end
            COAST: begin
               if (result_good) begin
                  state_d    = TRACK;
                  cx_d       = x_position;
                  cy_d       = y_position;
                  miss_cnt_d = '0;
               end else if (miss_cnt_q == MISS_MAX) begin
                  state_d    = IDLE;
                  miss_cnt_d = '0;
               end else begin
                  miss_cnt_d = miss_cnt_q + MISS_ONE;
               end
            end
            default: begin
               state_d    = IDLE;
               miss_cnt_d = '0;
            end
         endcase
      end
   end

   // One extra bit keeps the offsets signed without wrapping at the raster edges.
   always_comb begin
      dx  = $signed({1'b0, vga_x}) - $signed({1'b0, cx_q});
      dy  = $signed({1'b0, vga_y}) - $signed({1'b0, cy_q});
      adx = dx[XW-1] ? -dx : dx;
      ady = dy[XW-1] ? -dy : dy;
      hit = (adx <= BOX) && (ady <= BOX) && ((adx == BOX) || (ady == BOX));
   end

   always_comb begin
      pixel_out_d = pixel_in;
      if (enable && hit) begin
         if (state_q == TRACK) begin
            pixel_out_d = TRACK_COLOR;
         end else if (state_q == COAST) begin
            pixel_out_d = COAST_COLOR;
         end
      end
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q     <= IDLE;
         cx_q        <= '0;
         cy_q        <= '0;
         miss_cnt_q  <= '0;
         pixel_out_q <= '0;
      end else begin
         state_q     <= state_d;
         cx_q        <= cx_d;
         cy_q        <= cy_d;
         miss_cnt_q  <= miss_cnt_d;
         pixel_out_q <= pixel_out_d;
      end
   end

   assign pixel_out   = pixel_out_q;
   assign track_state = state_q;
   assign locked      = (state_q != IDLE);

endmodule

// File: tb/tb_position_overlay.sv
// Directed bench for position_overlay: a behavioural tracker/marker model checked every cycle,
// plus literal expectations at the key pixels and state transitions.
module tb_position_overlay;

   localparam int W  = 11;
   localparam int CF = 4;
   localparam int BH = 8;
   localparam logic [29:0] TC = 30'h3FF00000;
   localparam logic [29:0] CC = 30'h1FF7FC00;
   localparam logic [29:0] P  = 30'h0ABCDEF1;
   localparam logic [29:0] P2 = 30'h15555555;

   logic          clk = 1'b0;
   logic          aresetn = 1'b0;
   logic          enable = 1'b1;
   logic [W-1:0]  vga_x = '0, vga_y = '0;
   logic [29:0]   pixel_in = '0;
   logic [W-1:0]  x_position = '0, y_position = '0;
   logic          xy_valid = 1'b0;
   logic [29:0]   pixel_out;
   logic [1:0]    track_state;
   logic          locked;

   position_overlay dut (
      .clk(clk), .aresetn(aresetn), .enable(enable),
      .vga_x(vga_x), .vga_y(vga_y), .pixel_in(pixel_in),
      .x_position(x_position), .y_position(y_position), .xy_valid(xy_valid),
      .pixel_out(pixel_out), .track_state(track_state), .locked(locked)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: state as plain ints (0 idle, 1 track, 2 coast).
   int          m_st, m_cx, m_cy, m_miss;
   logic [29:0] exp_pix;

   function automatic bit on_outline(int x, int y, int cx, int cy);
      int ax, ay;
      ax = (x > cx) ? x - cx : cx - x;
      ay = (y > cy) ? y - cy : cy - y;
      return (ax <= BH) && (ay <= BH) && (ax == BH || ay == BH);
   endfunction

   function automatic logic [29:0] model_pix(int st, int x, int y, int cx, int cy, logic en, logic [29:0] pin);
      if (!en || st == 0 || !on_outline(x, y, cx, cy)) return pin;
      return (st == 1) ? TC : CC;
   endfunction

   always @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         m_st <= 0; m_cx <= 0; m_cy <= 0; m_miss <= 0; exp_pix <= '0;
      end else begin
         exp_pix <= model_pix(m_st, int'(vga_x), int'(vga_y), m_cx, m_cy, enable, pixel_in);
         if (!enable) begin
            m_st <= 0; m_cx <= 0; m_cy <= 0; m_miss <= 0;
         end else if (xy_valid) begin
            if (int'(x_position) < 640 && int'(y_position) < 480) begin
               m_st <= 1; m_cx <= int'(x_position); m_cy <= int'(y_position); m_miss <= 0;
            end else if (m_st == 1) begin
               m_st <= 2; m_miss <= 1;
            end else if (m_st == 2) begin
               if (m_miss == CF) begin m_st <= 0; m_miss <= 0; end
               else m_miss <= m_miss + 1;
            end
         end
      end
   end

   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         chk("model_pix", {2'b0, pixel_out}, {2'b0, exp_pix});
         chk("model_state", {30'b0, track_state}, 32'(m_st));
         chk("model_locked", {31'b0, locked}, {31'b0, (m_st != 0)});
      end
   end

   task automatic cyc(input logic [W-1:0] x, input logic [W-1:0] y, input logic [29:0] pin);
      vga_x = x; vga_y = y; pixel_in = pin;
      @(posedge clk); #1;
   endtask

   task automatic pulse(input logic [W-1:0] px, input logic [W-1:0] py);
      x_position = px; y_position = py; xy_valid = 1'b1;
      @(posedge clk); #1;
      xy_valid = 1'b0;
   endtask

   task automatic pix(input string n, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic [29:0] pin, input logic [29:0] exp);
      cyc(x, y, pin);
      chk(n, {2'b0, pixel_out}, {2'b0, exp});
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pix", {2'b0, pixel_out}, 32'h0);
      chk("rst_state", {30'b0, track_state}, 32'd0);
      chk("rst_locked", {31'b0, locked}, 32'd0);
      aresetn = 1'b1;
      pix("passthrough", 11'd0, 11'd0, 30'h12345678, 30'h12345678);

      pulse(11'd320, 11'd240);
      chk("acq_state", {30'b0, track_state}, 32'd1);
      chk("acq_locked", {31'b0, locked}, 32'd1);
      pix("mark_left", 11'd312, 11'd240, P, TC);
      pix("mark_right", 11'd328, 11'd235, P, TC);
      pix("mark_top", 11'd320, 11'd232, P, TC);
      pix("center", 11'd320, 11'd240, P, P);
      pix("outside", 11'd311, 11'd240, P, P);

      for (int i = 0; i < CF; i++) begin
         pulse('1, '1);
         chk("coast_state", {30'b0, track_state}, 32'd2);
      end
      pix("coast_mark", 11'd312, 11'd240, P, CC);
      pix("coast_center", 11'd320, 11'd240, P2, P2);
      pulse('1, '1);
      chk("drop_state", {30'b0, track_state}, 32'd0);
      chk("drop_locked", {31'b0, locked}, 32'd0);
      pix("drop_nomark", 11'd312, 11'd240, P, P);

      pulse(11'd320, 11'd240);
      pulse('1, '1);
      pulse('1, '1);
      chk("coast2_state", {30'b0, track_state}, 32'd2);
      pulse(11'd100, 11'd50);
      chk("reacq_state", {30'b0, track_state}, 32'd1);
      pix("new_mark", 11'd92, 11'd50, P, TC);
      pix("old_mark_gone", 11'd312, 11'd240, P, P);
      for (int i = 0; i < CF; i++) pulse('1, '1);
      chk("miss_reset_coast", {30'b0, track_state}, 32'd2);
      pulse('1, '1);
      chk("miss_reset_drop", {30'b0, track_state}, 32'd0);

      pulse(11'd3, 11'd3);
      for (int x = 0; x <= 11; x++) pix("edge_row", W'(x), 11'd11, P, TC);
      pix("edge_end", 11'd12, 11'd11, P, P);
      pix("edge_nowrap_2047", 11'd2047, 11'd11, P, P);
      pix("edge_nowrap_2044", 11'd2044, 11'd11, P, P);

      enable = 1'b0;
      pix("disable_pass", 11'd0, 11'd11, P2, P2);
      enable = 1'b1;
      chk("disable_state", {30'b0, track_state}, 32'd0);
      pix("disable_after", 11'd0, 11'd11, P, P);
      pulse(11'd640, 11'd10);
      chk("x_max_bad", {30'b0, track_state}, 32'd0);
      pulse(11'd10, 11'd480);
      chk("y_max_bad", {30'b0, track_state}, 32'd0);
      enable = 1'b0;
      pulse(11'd50, 11'd50);
      enable = 1'b1;
      chk("valid_ignored", {30'b0, track_state}, 32'd0);

      pulse(11'd320, 11'd240);
      pix("pre_reset_mark", 11'd312, 11'd240, P, TC);
      vga_x = 11'd313;
      #3 aresetn = 1'b0;
      #1;
      chk("arst_pix", {2'b0, pixel_out}, 32'h0);
      chk("arst_state", {30'b0, track_state}, 32'd0);
      @(posedge clk); #1;
      aresetn = 1'b1;
      chk("arst_hold_pix", {2'b0, pixel_out}, 32'h0);
      pix("post_reset_pass", 11'd312, 11'd240, P, P);
      repeat (2) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/position_overlay.md
# position_overlay

Consumes the per-frame centroid result (`x_position`, `y_position`, `xy_valid`) produced by the object position measurement stage and draws a square marker around the tracked object onto the outgoing VGA pixel stream. It sits between the video pipeline's pixel source and the VGA output and shares the same `vga_x`/`vga_y` raster counters. A small tracking state machine holds the last good position for a bounded number of frames when the object is lost, then drops the marker.

## Interface
Parameters:
- `INPUT_WIDTH`, 11, width of coordinates and position inputs
- `COLOR_WIDTH`, 10, width of one color channel
- `FRAME_X_MAX`, 640, x coordinate at the end-of-frame point; positions >= this are invalid
- `FRAME_Y_MAX`, 480, y coordinate at the end-of-frame point; positions >= this are invalid
- `BOX_HALF`, 8, marker half-size in pixels (outline at distance exactly BOX_HALF)
- `COAST_FRAMES`, 4, consecutive invalid results tolerated before dropping the target (>= 1)
- `TRACK_COLOR`, 30'h3FF00000, {R,G,B} marker color while tracking
- `COAST_COLOR`, 30'h1FF7FC00, {R,G,B} marker color while coasting

Ports:
- `clk`  in  1  pixel clock
- `aresetn`  in  1  asynchronous, active-low reset
- `enable`  in  1  high = overlay active; low = passthrough and clear tracking
- `vga_x`  in  INPUT_WIDTH  current raster x
- `vga_y`  in  INPUT_WIDTH  current raster y
- `pixel_in`  in  3*COLOR_WIDTH  {R,G,B} pixel for (`vga_x`,`vga_y`)
- `x_position`  in  INPUT_WIDTH  centroid x; all-ones = no object
- `y_position`  in  INPUT_WIDTH  centroid y; all-ones = no object
- `xy_valid`  in  1  one-cycle pulse qualifying the position inputs
- `pixel_out`  out  3*COLOR_WIDTH  registered output pixel
- `track_state`  out  2  0 = IDLE, 1 = TRACK, 2 = COAST
- `locked`  out  1  high in TRACK or COAST

## Operation
- Result sampled only on cycles with `xy_valid`=1 and `enable`=1. A result is good iff `x_position` < FRAME_X_MAX and `y_position` < FRAME_Y_MAX (so all-ones is bad).
- Registers: `cx`, `cy` (INPUT_WIDTH), `miss_cnt` (wide enough for COAST_FRAMES), state.
- IDLE: good -> latch cx/cy, TRACK. Bad -> stay.
- TRACK: good -> latch, stay. Bad -> COAST, `miss_cnt`=1, cx/cy held.
- COAST: good -> latch, `miss_cnt`=0, TRACK. Bad -> if `miss_cnt`==COAST_FRAMES then IDLE, `miss_cnt`=0; else `miss_cnt`+1.
- So the target drops on the (COAST_FRAMES+1)th consecutive bad result.
- Marker hit: dx = `vga_x`-cx, dy = `vga_y`-cy computed signed at INPUT_WIDTH+1 bits (no wrap). hit iff |dx|<=BOX_HALF and |dy|<=BOX_HALF and (|dx|==BOX_HALF or |dy|==BOX_HALF). Portions outside the frame are simply never rasterized; no clamping.
- `pixel_out` = TRACK_COLOR on hit in TRACK, COAST_COLOR on hit in COAST, else `pixel_in`.
- `enable`=0: state IDLE, `miss_cnt`=0, cx/cy=0, `pixel_out` = `pixel_in` (registered).

## Timing
- Reset: `pixel_out`=0, `track_state`=0, `locked`=0, cx=cy=0, `miss_cnt`=0.
- `pixel_out` latency: 1 cycle. `pixel_out` at cycle n+1 corresponds to `vga_x`/`vga_y`/`pixel_in` at cycle n. Hit uses cx/cy/state as registered at cycle n.
- State/cx/cy update the cycle after `xy_valid`. Since `xy_valid` fires at the end-of-frame point, a new position takes effect from the next frame's first pixel.
- `track_state`/`locked` are registered, same cycle as the state register.
- `xy_valid` while `enable`=0 is ignored.
- Reset mid-frame: all registers clear immediately (async); `pixel_out`=0 until the first clock after release.
- No handshake back to the producer; each pulse is consumed unconditionally.

## Test plan
- Reset then passthrough: hold `aresetn`=0 -> `pixel_out`=0, `track_state`=0. Release, `pixel_in`=30'h12345678 with no `xy_valid` -> `pixel_out`=30'h12345678 one cycle later.
- Acquire and draw: pulse `xy_valid` with (320,240) -> TRACK next cycle. Next frame, pixels (312,240), (328,235), (320,232) = TRACK_COLOR; (320,240) and (311,240) = `pixel_in`.
- Coast and drop (COAST_FRAMES=4): after TRACK, 4 all-ones results -> COAST with COAST_COLOR marker kept at (320,240). 5th bad result -> IDLE, `locked`=0, no marker.
- Reacquire: in COAST after 2 bad results, good (100,50) -> TRACK, `miss_cnt`=0, marker moves to (100,50).
- Edge and invalid: good (3,3) -> outline row y=11 drawn for x=0..11, no wrap to x near 2047. Result (640,10) treated as bad (IDLE stays IDLE).
- Enable/reset mid-op: in TRACK, drop `enable` for 1 cycle -> IDLE, passthrough. Async reset mid-line -> outputs 0 immediately.
